// File: rtl/clock_set_ctrl_pkg.sv
// Shared types, defaults and BCD helpers for the clock-setting controller.
package clock_set_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_BLINK_CYCLES    = 25_000_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 1_000_000_000;

    typedef struct packed {
        logic [3:0] hr_t;
        logic [3:0] hr_u;
        logic [3:0] mn_t;
        logic [3:0] mn_u;
    } bcd_time_t;

    localparam bcd_time_t RST_TIME = '{hr_t: 4'd1, hr_u: 4'd2, mn_t: 4'd0, mn_u: 4'd0};

    // Anything that is not a legal 12-hour time is forced to a sane default per field.
    function automatic bcd_time_t sanitize(input bcd_time_t t);
        bcd_time_t  r;
        logic [7:0] hr;
        logic [7:0] mn;
        r  = t;
        hr = 8'(t.hr_t) * 8'd10 + 8'(t.hr_u);
        mn = 8'(t.mn_t) * 8'd10 + 8'(t.mn_u);
        if (t.hr_t > 4'd9 || t.hr_u > 4'd9 || hr < 8'd1 || hr > 8'd12) begin
            r.hr_t = 4'd1;
            r.hr_u = 4'd2;
        end
        if (t.mn_t > 4'd9 || t.mn_u > 4'd9 || mn > 8'd59) begin
            r.mn_t = 4'd0;
            r.mn_u = 4'd0;
        end
        return r;
    endfunction

    function automatic bcd_time_t hr_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.hr_t == 4'd1 && t.hr_u == 4'd2) begin
            r.hr_t = 4'd0;
            r.hr_u = 4'd1;
        end else if (t.hr_u == 4'd9) begin
            r.hr_t = t.hr_t + 4'd1;
            r.hr_u = 4'd0;
        end else begin
            r.hr_u = t.hr_u + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_time_t mn_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.mn_t == 4'd5 && t.mn_u == 4'd9) begin
            r.mn_t = 4'd0;
            r.mn_u = 4'd0;
        end else if (t.mn_u == 4'd9) begin
            r.mn_t = t.mn_t + 4'd1;
            r.mn_u = 4'd0;
        end else begin
            r.mn_u = t.mn_u + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debounce, one-cycle press pulse.
module btn_debounce
    import clock_set_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [1:0]    fill_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          armed_q;
    logic          press_q;
    logic          s;

    assign s       = sync_q[1];
    assign press_o = press_q;

    // armed_q stays low until the synchronized input has really been seen low,
    // so a button held through reset cannot produce a press on release of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            fill_q  <= {fill_q[0], 1'b1};
            press_q <= 1'b0;
            if (fill_q[1] && !s) armed_q <= 1'b1;
            if (s == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q   <= '0;
                level_q <= s;
                press_q <= s & armed_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting front end: two buttons walk RUN -> SET_HR -> SET_MIN -> COMMIT.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned BLINK_CYCLES    = DEF_BLINK_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_bcd3,
    input  logic [3:0] cur_bcd2,
    input  logic [3:0] cur_bcd1,
    input  logic [3:0] cur_bcd0,
    output logic       hold,
    output logic       load,
    output logic [3:0] set_bcd3,
    output logic [3:0] set_bcd2,
    output logic [3:0] set_bcd1,
    output logic [3:0] set_bcd0,
    output logic [3:0] blink_mask,
    output logic [1:0] state_o
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic          mode_p, inc_p;
    state_e        state_q, state_d;
    bcd_time_t     edit_q, edit_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    mask_d, mask_q;
    logic          hold_q, load_q;
    logic          in_set, timeout;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .rst(rst), .btn_i(btn_mode), .press_o(mode_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .rst(rst), .btn_i(btn_inc), .press_o(inc_p)
    );

    assign in_set  = (state_q == SET_HR) || (state_q == SET_MIN);
    assign timeout = in_set && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // mode_p is checked first everywhere so a simultaneous inc_p is dropped.
    always_comb begin
        state_d = state_q;
        edit_d  = edit_q;
        case (state_q)
            RUN: if (mode_p) begin
                state_d = SET_HR;
                edit_d  = sanitize({cur_bcd3, cur_bcd2, cur_bcd1, cur_bcd0});
            end
            SET_HR: begin
                if (mode_p)       state_d = SET_MIN;
                else if (inc_p)   edit_d  = hr_inc(edit_q);
                else if (timeout) state_d = RUN;
            end
            SET_MIN: begin
                if (mode_p)       state_d = COMMIT;
                else if (inc_p)   edit_d  = mn_inc(edit_q);
                else if (timeout) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (!in_set || state_d != state_q || mode_p || inc_p) to_cnt_d = '0;

        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (state_d == SET_HR && state_q != SET_HR) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        mask_d = 4'b0000;
        if (phase_d && state_d == SET_HR)  mask_d = 4'b1100;
        if (phase_d && state_d == SET_MIN) mask_d = 4'b0011;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            edit_q      <= RST_TIME;
            to_cnt_q    <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            mask_q      <= '0;
            hold_q      <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            edit_q      <= edit_d;
            to_cnt_q    <= to_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            mask_q      <= mask_d;
            hold_q      <= (state_d != RUN);
            load_q      <= (state_d == COMMIT);
        end
    end

    assign state_o    = state_q;
    assign hold       = hold_q;
    assign load       = load_q;
    assign blink_mask = mask_q;
    assign {set_bcd3, set_bcd2, set_bcd1, set_bcd0} = edit_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized scoreboard bench for clock_set_ctrl against an arithmetic time model.
module tb_clock_set_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur3 = 4'd0, cur2 = 4'd0, cur1 = 4'd0, cur0 = 4'd0;
    logic       hold, load;
    logic [3:0] set3, set2, set1, set0, blink_mask;
    logic [1:0] state_o;

    int n_pass = 0;
    int n_total = 0;
    logic [15:0] exp_q[$];
    bit          hold_chk = 1'b0;

    int m_st, m_hr, m_mn;

    always #5 clk = ~clk;

    clock_set_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_bcd3(cur3), .cur_bcd2(cur2), .cur_bcd1(cur1), .cur_bcd0(cur0),
        .hold(hold), .load(load),
        .set_bcd3(set3), .set_bcd2(set2), .set_bcd1(set1), .set_bcd0(set0),
        .blink_mask(blink_mask), .state_o(state_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] bcd(input int h, input int m);
        logic [3:0] a, b, c, d;
        a = 4'(h / 10); b = 4'(h % 10); c = 4'(m / 10); d = 4'(m % 10);
        return {a, b, c, d};
    endfunction

    // Monitor: every load must match the oldest expected commit; hold drops next cycle.
    always @(negedge clk) begin
        if (hold_chk) begin
            chk("hold_after_load", {30'd0, hold, load}, 32'd0);
            hold_chk = 1'b0;
        end
        if (load) begin
            chk("load_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                chk("load_value", {16'd0, set3, set2, set1, set0}, {16'd0, exp_q.pop_front()});
                chk("hold_at_load", {31'd0, hold}, 32'd1);
            end
            hold_chk = 1'b1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_st = 0; m_hr = 12; m_mn = 0;
    endtask

    task automatic set_cur(input logic [15:0] v);
        {cur3, cur2, cur1, cur0} = v;
    endtask

    function automatic int san_hr(input int t, input int u);
        int v;
        v = t * 10 + u;
        return (t > 9 || u > 9 || v < 1 || v > 12) ? 12 : v;
    endfunction

    function automatic int san_mn(input int t, input int u);
        int v;
        v = t * 10 + u;
        return (t > 9 || u > 9 || v > 59) ? 0 : v;
    endfunction

    task automatic model_apply(input bit m, input bit i);
        if (m) begin
            case (m_st)
                0: begin
                    m_hr = san_hr(int'(cur3), int'(cur2));
                    m_mn = san_mn(int'(cur1), int'(cur0));
                    m_st = 1;
                end
                1: m_st = 2;
                default: begin
                    exp_q.push_back(bcd(m_hr, m_mn));
                    m_st = 0;
                end
            endcase
        end else if (i) begin
            if (m_st == 1) m_hr = (m_hr == 12) ? 1 : m_hr + 1;
            if (m_st == 2) m_mn = (m_mn + 1) % 60;
        end
    endtask

    task automatic press(input bit m, input bit i);
        model_apply(m, i);
        btn_mode = m; btn_inc = i;
        cycles(10);
        btn_mode = 1'b0; btn_inc = 1'b0;
        cycles(10);
    endtask

    task automatic check_state(input string nm);
        @(negedge clk);
        chk({nm, "_state"}, {30'd0, state_o}, m_st);
        chk({nm, "_set"}, {16'd0, set3, set2, set1, set0}, {16'd0, bcd(m_hr, m_mn)});
        chk({nm, "_hold"}, {31'd0, hold}, (m_st != 0) ? 32'd1 : 32'd0);
        if (m_st == 0) chk({nm, "_mask"}, {28'd0, blink_mask}, 32'd0);
    endtask

    task automatic blink_scan(input string nm, input logic [3:0] on_val);
        int bad = 0;
        int ones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (blink_mask == on_val) ones++;
            else if (blink_mask != 4'b0000) bad++;
        end
        chk({nm, "_legal"}, bad, 0);
        chk({nm, "_seen"}, (ones > 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_load", {31'd0, load}, 32'd0);
        check_state("rst");

        // Short glitch must be rejected, a proper hold accepted exactly once.
        btn_mode = 1'b1; cycles(3); btn_mode = 1'b0; cycles(12);
        check_state("glitch");
        set_cur(16'h1158);
        press(1, 0); check_state("enter_hr");
        blink_scan("blink_hr", 4'b1100);
        press(0, 1); press(0, 1); check_state("hr_wrap");
        press(1, 0); check_state("enter_min");
        blink_scan("blink_min", 4'b0011);
        press(0, 1); press(0, 1); press(0, 1); check_state("min_wrap");
        press(1, 0); cycles(2); check_state("commit1");

        set_cur(16'h0900);
        press(1, 0); press(0, 1); check_state("hr_09_10");
        press(1, 0); press(1, 0); cycles(2);
        set_cur(16'h1259);
        press(1, 0); press(1, 0); press(0, 1); check_state("min_59_00");
        press(1, 0); cycles(2);

        set_cur(16'h1375);
        press(1, 0); check_state("sanitize");
        press(1, 0);
        cycles(50); check_state("pre_timeout");
        cycles(60); m_st = 0; check_state("timeout");

        set_cur(16'h0345);
        press(1, 0); press(1, 1); check_state("mode_wins");
        press(0, 1); check_state("min_inc");
        rst = 1'b1; cycles(2); rst = 1'b0;
        model_reset(); check_state("rst_in_min");

        // A button held through reset must not produce a press until re-pressed.
        btn_mode = 1'b1; rst = 1'b1; cycles(2); rst = 1'b0; cycles(20);
        check_state("held_thru_rst");
        btn_mode = 1'b0; cycles(10);
        press(1, 0); check_state("after_release");

        for (int it = 0; it < 40; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2)      set_cur(16'($urandom));
            else if (r < 6) press(1, 0);
            else if (r < 9) press(0, 1);
            else            press(1, 1);
            if (r >= 2) check_state("rand");
        end
        if (m_st == 1) press(1, 0);
        if (m_st == 2) press(1, 0);
        cycles(5);
        chk("queue_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
